// File: rtl/apb_sram_pkg.sv
// apb_sram_pkg: state encoding and address helpers shared by apb_sram_ctrl.
package apb_sram_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD1  = 3'd2,
      RD2  = 3'd3,
      ERR  = 3'd4
   } state_e;

   function automatic int unsigned calc_bo(input int unsigned datawidth);
      return $clog2(datawidth / 32'd8);
   endfunction

   function automatic logic addr_legal(input logic [63:0]  paddr,
                                       input int unsigned  depth,
                                       input int unsigned  bytes_per_word);
      logic [63:0] limit;
      logic [63:0] lsb_mask;
      limit    = 64'(depth) * 64'(bytes_per_word);
      lsb_mask = 64'(bytes_per_word) - 64'd1;
      return ((paddr & lsb_mask) == 64'd0) && (paddr < limit);
   endfunction

endpackage

// File: rtl/apb_sram_ctrl.sv
// apb_sram_ctrl: APB3 slave driving a 1-cycle-read-latency single-port RAM.
// Build option: define APB_SRAM_SLVERR_EN to flag illegal addresses via the ERR state.
module apb_sram_ctrl
   import apb_sram_pkg::*;
#(
   parameter int unsigned DATAWIDTH  = 32,
   parameter int unsigned RAM_DEPTH  = 128,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [ADDR_WIDTH-1:0]        paddr,
   input  logic [DATAWIDTH-1:0]         pwdata,
   output logic [DATAWIDTH-1:0]         prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic                         ram_sel,
   output logic                         ram_we,
   output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
   output logic [DATAWIDTH-1:0]         ram_wdata,
   input  logic [DATAWIDTH-1:0]         ram_rdata
);

   localparam int unsigned BO  = calc_bo(DATAWIDTH);
   localparam int unsigned AW  = $clog2(RAM_DEPTH);
   localparam int unsigned BPW = DATAWIDTH / 32'd8;

   state_e                 state_q, state_d;
   logic                   ram_sel_q, ram_sel_d;
   logic                   ram_we_q, ram_we_d;
   logic [AW-1:0]          ram_addr_q, ram_addr_d;
   logic [DATAWIDTH-1:0]   ram_wdata_q, ram_wdata_d;
   logic [AW-1:0]          widx_s;
   logic                   setup_s;
   logic                   legal_s;

   assign widx_s  = paddr[BO+AW-1:BO];
   assign setup_s = psel & ~penable;

`ifdef APB_SRAM_SLVERR_EN
   assign legal_s = addr_legal(64'(paddr), RAM_DEPTH, BPW);
`else
   // Every address maps onto a word: offset bits and upper bits are dropped.
   logic unused_paddr_s;
   assign unused_paddr_s = ^paddr;
   assign legal_s        = 1'b1;
`endif

   // Next-state and RAM-control next values.
   always_comb begin
      state_d     = state_q;
      ram_sel_d   = ram_sel_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      case (state_q)
         IDLE: begin
            if (setup_s && legal_s) begin
               ram_sel_d  = 1'b1;
               ram_we_d   = pwrite;
               ram_addr_d = widx_s;
               if (pwrite) begin
                  ram_wdata_d = pwdata;
                  state_d     = WR;
               end else begin
                  state_d = RD1;
               end
            end
`ifdef APB_SRAM_SLVERR_EN
            else if (setup_s) begin
               state_d = ERR;
            end
`endif
            else begin
               state_d = IDLE;
            end
         end
         WR: begin
            ram_sel_d = 1'b0;
            ram_we_d  = 1'b0;
            state_d   = IDLE;
         end
         RD1: begin
            // Dropping psel here aborts the read before the response phase.
            ram_sel_d = 1'b0;
            ram_we_d  = 1'b0;
            if (psel) begin
               state_d = RD2;
            end else begin
               state_d = IDLE;
            end
         end
         RD2: begin
            state_d = IDLE;
         end
`ifdef APB_SRAM_SLVERR_EN
         ERR: begin
            state_d = IDLE;
         end
`endif
         default: begin
            ram_sel_d = 1'b0;
            ram_we_d  = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   // State and RAM-control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         ram_sel_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= {AW{1'b0}};
         ram_wdata_q <= {DATAWIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         ram_sel_q   <= ram_sel_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   // Moore decode of the APB response from the state register.
   always_comb begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = {DATAWIDTH{1'b0}};
      case (state_q)
         WR: begin
            pready = 1'b1;
         end
         RD2: begin
            pready = 1'b1;
            prdata = ram_rdata;
         end
`ifdef APB_SRAM_SLVERR_EN
         ERR: begin
            pready  = 1'b1;
            pslverr = 1'b1;
         end
`endif
         default: begin
            pready = 1'b0;
         end
      endcase
   end

   assign ram_sel   = ram_sel_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// tb_apb_sram_ctrl: randomized APB traffic against a word-array reference model with queued expectations.
module tb_apb_sram_ctrl;

   localparam int DW    = 32;
   localparam int DEPTH = 128;
   localparam int AWID  = 32;
   localparam int BPW   = DW / 8;

   logic            clk = 1'b0;
   logic            rstn, psel, penable, pwrite;
   logic [AWID-1:0] paddr;
   logic [DW-1:0]   pwdata, prdata, ram_wdata, ram_rdata;
   logic            pready, pslverr, ram_sel, ram_we;
   logic [6:0]      ram_addr;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          slverr;
      int            lat;
      bit            chk_data;
   } resp_t;

   typedef struct {
      logic          we;
      logic [6:0]    addr;
      logic [DW-1:0] wdata;
   } ramop_t;

   resp_t         exp_q[$];
   ramop_t        ram_q[$];
   logic [DW-1:0] ref_mem[int];
   logic [DW-1:0] ram_mem[DEPTH];
   int            total = 0;
   int            bad = 0;
   int            acc = 0;
   resp_t         mr;
   ramop_t        mo;

   always #5 clk = ~clk;

   apb_sram_ctrl #(.DATAWIDTH(DW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AWID)) dut (
      .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .ram_sel(ram_sel), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // Single-port RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (ram_sel) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   // Reference: a transfer either errors, or maps to word (addr/bytes) mod depth.
   function automatic void model(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                 input bit respond);
      resp_t  r;
      ramop_t op;
      int     w;
      bit     legal;
`ifdef APB_SRAM_SLVERR_EN
      legal = (a % BPW == 0) && (a < DEPTH * BPW);
`else
      legal = 1'b1;
`endif
      w          = int'((a / BPW) % DEPTH);
      r.slverr   = !legal;
      r.rdata    = '0;
      r.chk_data = 1'b1;
      r.lat      = (legal && !wr) ? 2 : 1;
      if (legal) begin
         op.we    = wr;
         op.addr  = w[6:0];
         op.wdata = d;
         ram_q.push_back(op);
         if (wr) ref_mem[w] = d;
         else if (ref_mem.exists(w)) r.rdata = ref_mem[w];
         else r.chk_data = 1'b0;
      end
      if (respond) exp_q.push_back(r);
   endfunction

   // Monitor: APB completions and RAM strobes are popped from their queues.
   always @(negedge clk) begin
      if (!rstn || !(psel && penable)) begin
         acc = 0;
      end else begin
         acc = acc + 1;
         if (pready) begin
            if (exp_q.size() == 0) begin
               chk("pready_unexpected", 64'(pready), 64'd0);
            end else begin
               mr = exp_q.pop_front();
               if (mr.chk_data) chk("prdata", 64'(prdata), 64'(mr.rdata));
               chk("pslverr", 64'(pslverr), 64'(mr.slverr));
               chk("latency", 64'(acc), 64'(mr.lat));
            end
            acc = 0;
         end
      end
      if (ram_sel) begin
         if (ram_q.size() == 0) begin
            chk("ram_sel_unexpected", 64'(ram_sel), 64'd0);
         end else begin
            mo = ram_q.pop_front();
            chk("ram_we", 64'(ram_we), 64'(mo.we));
            chk("ram_addr", 64'(ram_addr), 64'(mo.addr));
            if (mo.we) chk("ram_wdata", 64'(ram_wdata), 64'(mo.wdata));
         end
      end else begin
         chk("ram_we_idle", 64'(ram_we), 64'd0);
      end
   end

   task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d);
      int n;
      model(wr, a, d, 1'b1);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pready && n < 8);
      chk("pready_timeout", 64'(pready), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      psel = 1'b0; penable = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit            wr;
      logic [31:0]   a;
      rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ram_sel", 64'(ram_sel), 64'd0);
      chk("rst_ram_addr", 64'(ram_addr), 64'd0);
      chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
      chk("rst_pready", 64'(pready), 64'd0);
      chk("rst_pslverr", 64'(pslverr), 64'd0);
      chk("rst_prdata", 64'(prdata), 64'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      idle(2);

      // Single write then read.
      xfer(1'b1, 32'h10, 32'hDEADBEEF);
      idle(1);
      xfer(1'b0, 32'h10, 32'h0);
      idle(1);

      // Back-to-back transfers with no gap.
      xfer(1'b1, 32'h0,   32'h11111111);
      xfer(1'b1, 32'h1FC, 32'h22222222);
      xfer(1'b0, 32'h0,   32'h0);
      xfer(1'b0, 32'h1FC, 32'h0);
      idle(1);

      // Out-of-range and misaligned addresses.
      xfer(1'b0, 32'h200, 32'h0);
      xfer(1'b1, 32'h6,   32'h12345678);
      idle(1);
      xfer(1'b1, 32'h200, 32'hA5A5A5A5);
      xfer(1'b0, 32'h0,   32'h0);
      idle(1);

      // Reset asserted while the read sits in RD1.
      model(1'b0, 32'h10, 32'h0, 1'b0);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
      @(posedge clk); #1;
      penable = 1'b1; rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_ram_sel", 64'(ram_sel), 64'd0);
      chk("midrst_ram_addr", 64'(ram_addr), 64'd0);
      chk("midrst_pready", 64'(pready), 64'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      idle(1);
      xfer(1'b0, 32'h10, 32'h0);
      idle(1);

      // psel dropped during RD1.
      model(1'b0, 32'h1FC, 32'h0, 1'b0);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h1FC;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_ram_sel", 64'(ram_sel), 64'd0);
      chk("abort_pready", 64'(pready), 64'd0);
      @(negedge clk);
      chk("abort_pready_late", 64'(pready), 64'd0);
      @(posedge clk); #1;
      xfer(1'b0, 32'h1FC, 32'h0);

      // Random traffic, mostly aligned, with random gaps.
      for (int i = 0; i < 200; i++) begin
         wr = 1'($urandom % 2);
         if ($urandom % 4 == 0) a = 32'($urandom_range(0, 1023));
         else                   a = 32'($urandom_range(0, 127)) * 32'd4;
         xfer(wr, a, $urandom);
         idle(int'($urandom % 3));
      end

      idle(4);
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      chk("ram_q_empty", 64'(ram_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_sram_ctrl.md
Name: apb_sram_ctrl

Overview:
APB3 slave that converts APB transfers into single-port RAM accesses on the sel/we/addr/wdata/rdata RAM interface. It is the initiator end of the RAM interface and is paired with the 1-cycle-read-latency single-port RAM inside the apb_sram subsystem. It registers all RAM-side controls, inserts one wait state on reads, and flags illegal addresses.

Parameters:
DATAWIDTH, 32, APB and RAM data width in bits; must be a multiple of 8.
RAM_DEPTH, 128, number of RAM words.
ADDR_WIDTH, 32, APB byte-address width.

Ports:
clk  input  1  clock; all logic on rising edge.
rstn  input  1  synchronous active-low reset.
psel  input  1  APB select.
penable  input  1  APB enable; high in the access phase.
pwrite  input  1  1 = write, 0 = read.
paddr  input  ADDR_WIDTH  APB byte address.
pwdata  input  DATAWIDTH  APB write data.
prdata  output  DATAWIDTH  APB read data.
pready  output  1  transfer completes this cycle.
pslverr  output  1  error response; valid only while pready=1.
ram_sel  output  1  RAM access strobe; registered.
ram_we  output  1  RAM write enable; registered.
ram_addr  output  $clog2(RAM_DEPTH)  RAM word address; registered.
ram_wdata  output  DATAWIDTH  RAM write data; registered.
ram_rdata  input  DATAWIDTH  RAM read data; valid one cycle after a read strobe.

Behaviour:
- Reset: clk is the only clock; rstn is synchronous and active-low. While rstn=0, at each clock edge: state=IDLE; ram_sel, ram_we, ram_addr, ram_wdata = 0. prdata, pready and pslverr decode to 0.
- Word index: widx = paddr[BO+$clog2(RAM_DEPTH)-1:BO], where BO = $clog2(DATAWIDTH/8).
- Address is illegal when paddr[BO-1:0] != 0, or when paddr >= RAM_DEPTH*(DATAWIDTH/8).
- Setup phase: psel=1 and penable=0. It is sampled only in the IDLE state.
- FSM states (Moore outputs):
  - IDLE: pready=0. On a setup phase:
    - illegal address -> ERR.
    - pwrite=1 -> WR; at the same edge load ram_sel=1, ram_we=1, ram_addr=widx, ram_wdata=pwdata.
    - pwrite=0 -> RD1; at the same edge load ram_sel=1, ram_we=0, ram_addr=widx.
  - WR: pready=1, pslverr=0. The RAM captures the write at the end of this cycle. Next edge: ram_sel=0, ram_we=0, state -> IDLE.
  - RD1: pready=0 (one wait state). The RAM reads at the end of this cycle. Next edge: ram_sel=0, state -> RD2.
  - RD2: pready=1, prdata=ram_rdata. Next edge: state -> IDLE.
  - ERR: pready=1, pslverr=1, prdata=0. No RAM strobe is issued. Next edge: state -> IDLE.
- prdata = 0 in every state except RD2.
- Latency:
  - Write: setup + 1 access cycle.
  - Read: setup + 2 access cycles.
  - Error: setup + 1 access cycle.
- Back-to-back transfers: the cycle after pready=1 is in IDLE and accepts a new setup phase, so there is no idle gap.
- ram_sel is high for exactly one cycle per legal transfer.
- Protocol abort: psel=0 while in WR or RD1 -> IDLE next edge, with ram_sel and ram_we cleared.
  - A write already strobed in WR still completes in the RAM.
- A setup phase arriving while not in IDLE is ignored (APB forbids it).
- Reset mid-transfer: the next edge with rstn=0 forces IDLE and clears all RAM controls. No partial write is issued after that edge.

Optional Feature:
APB_SRAM_SLVERR_EN:
- Defined: illegal-address checking is active as described above, and the ERR state exists.
- Undefined: the ERR state is removed and pslverr is tied to 0. Every address is legal: paddr[BO-1:0] is ignored and widx wraps modulo RAM_DEPTH (upper bits are dropped).

Decomposition:
- apb_sram_pkg contains:
  - the state enum (IDLE, WR, RD1, RD2, ERR);
  - a localparam function computing BO from DATAWIDTH;
  - a function addr_legal(paddr, depth, bytes_per_word).
- No sub-module is required. The block is a single FSM plus output registers.
- Top-level pairing with the RAM lives in apb_sram_top, which is outside this block.

Test Plan:
1. Write 0xDEADBEEF to paddr 0x10, then read 0x10. Required response:
   - write: ram_sel/ram_we high for 1 cycle with ram_addr=4, pready in access cycle 1, pslverr=0;
   - read: pready in access cycle 2, prdata=0xDEADBEEF.
2. Back-to-back: write 0x11111111 @0x0, write 0x22222222 @0x1FC, read 0x0, read 0x1FC, with no idle cycles between transfers. Required response: reads return 0x11111111 and 0x22222222; ram_addr values are 0 and 127.
3. With the macro defined, read 0x200 and write 0x6. Required response: each completes with pready=1 and pslverr=1 in access cycle 1; ram_sel never asserts; prdata=0.
4. With the macro undefined, write 0xA5A5A5A5 @0x200, then read 0x0. Required response: ram_addr=0 on the write, and the read returns 0xA5A5A5A5.
5. Drive rstn=0 during RD1. Required response: the next edge gives ram_sel=0, pready=0, state IDLE; a following read @0x10 completes normally.
6. Drop psel during RD1. Required response: FSM returns to IDLE; no pready pulse; ram_sel=0 on the next cycle.
